// File: rtl/cpu_pkg.sv
// Shared CPU execute-stage definitions.
// Multiply/divide op encodings and FSM state type.
package cpu_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_FIX
    } md_state_t;

    // Signed variants have op[0] clear; divides have op[1] set.
    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative multiplier/divider.
// Multiply: right-shift shift-add. Divide: left-shift restoring step.
module muldiv_step
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum_d;
    logic [WIDTH:0] trial_d;

    // Combinational step: add-and-shift or trial-subtract-and-shift.
    always_comb begin
        sum_d   = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
                + {1'b0, (acc_i[0] ? opnd_i : {WIDTH{1'b0}})};
        trial_d = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_i};
        acc_o   = {sum_d, acc_i[WIDTH-1:1]};
        if (is_div_i) begin
            if (trial_d[WIDTH]) begin
                acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
            end else begin
                acc_o = {trial_d[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// One step per cycle, then a sign-fix cycle before results land.
module muldiv_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          state_q;
    logic [1:0]         op_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   a_q;
    logic               bz_q;
    logic               sa_q;
    logic               sb_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   abs_a_d;
    logic [WIDTH-1:0]   abs_b_d;
    logic               sa_d;
    logic               sb_d;
    logic [WIDTH-1:0]   hi_fix_d;
    logic [WIDTH-1:0]   lo_fix_d;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH-1:0]   quot_d;
    logic [WIDTH-1:0]   rem_d;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (op_q[1]),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (acc_d)
    );

    // Operand magnitudes and sign flags for the incoming request.
    always_comb begin
        sa_d    = md_is_signed(op) & a[WIDTH-1];
        sb_d    = md_is_signed(op) & b[WIDTH-1];
        abs_a_d = sa_d ? -a : a;
        abs_b_d = sb_d ? -b : b;
    end

    // Sign correction and divide-by-zero override applied in FIX.
    always_comb begin
        prod_d   = acc_q;
        quot_d   = acc_q[WIDTH-1:0];
        rem_d    = acc_q[2*WIDTH-1:WIDTH];
        hi_fix_d = acc_q[2*WIDTH-1:WIDTH];
        lo_fix_d = acc_q[WIDTH-1:0];
        if (!op_q[1]) begin
            if (sa_q ^ sb_q) begin
                prod_d = -acc_q;
            end
            hi_fix_d = prod_d[2*WIDTH-1:WIDTH];
            lo_fix_d = prod_d[WIDTH-1:0];
        end else if (bz_q) begin
            hi_fix_d = a_q;
            lo_fix_d = {WIDTH{1'b1}};
        end else begin
            lo_fix_d = (sa_q ^ sb_q) ? -quot_d : quot_d;
            hi_fix_d = sa_q ? -rem_d : rem_d;
        end
    end

    // Control FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MD_IDLE;
            op_q    <= MD_MULT;
            acc_q   <= '0;
            opnd_q  <= '0;
            a_q     <= '0;
            bz_q    <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                MD_IDLE: begin
                    if (start) begin
                        op_q    <= op;
                        a_q     <= a;
                        bz_q    <= (b == '0);
                        sa_q    <= sa_d;
                        sb_q    <= sb_d;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= MD_CALC;
                        if (op[1]) begin
                            acc_q  <= {{WIDTH{1'b0}}, abs_a_d};
                            opnd_q <= abs_b_d;
                        end else begin
                            acc_q  <= {{WIDTH{1'b0}}, abs_b_d};
                            opnd_q <= abs_a_d;
                        end
                    end else begin
                        if (mthi) hi_q <= wdata;
                        if (mtlo) lo_q <= wdata;
                    end
                end
                MD_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= MD_FIX;
                    end
                end
                MD_FIX: begin
                    hi_q    <= hi_fix_d;
                    lo_q    <= lo_fix_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= MD_IDLE;
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit.
// Expected HI/LO pairs are queued at issue; a monitor checks them on done.
module tb_muldiv_unit;
    import cpu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int passed = 0;
    int total  = 0;

    logic [2*W-1:0] exp_q[$];

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got done=1 expected no done");
            end else begin
                logic [2*W-1:0] e;
                e = exp_q.pop_front();
                chk("hi", hi, e[2*W-1:W]);
                chk("lo", lo, e[W-1:0]);
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] eh,
                         input logic [W-1:0] el, input bit push);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (push) exp_q.push_back({eh, el});
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 32'h0BAD_0BAD;
        b     = 32'h0BAD_0BAD;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            $display("FAIL done_timeout: got no done expected done");
        end
    endtask

    initial begin
        int errs;
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);

        @(posedge clk); #1;
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001, 1);
        errs = 0;
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            if (!busy || done) errs++;
        end
        chk("busy_window", errs, 0);
        @(negedge clk);
        chk("done_t34", {31'h0, done}, 32'h1);
        chk("busy_t34", {31'h0, busy}, 32'h0);

        @(posedge clk); #1;
        issue(MD_MULT, 32'hFFFF_FFFD, 32'h7,
              32'hFFFF_FFFF, 32'hFFFF_FFEB, 1);
        wait_done();
        @(posedge clk); #1;
        issue(MD_DIV, 32'hFFFF_FFF9, 32'h2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 1);
        wait_done();
        @(posedge clk); #1;
        issue(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1);
        wait_done();
        @(posedge clk); #1;
        issue(MD_DIVU, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, 1);
        wait_done();
        @(posedge clk); #1;
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h0, 32'h8000_0000, 1);
        wait_done();

        @(posedge clk); #1;
        issue(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = MD_MULTU; a = 32'd5; b = 32'd5;
        mthi = 1'b1; wdata = 32'h0000_AAAA;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);
        chk("no_requeue_busy", {31'h0, busy}, 32'h0);

        @(posedge clk); #1;
        issue(MD_MULTU, 32'd3, 32'd4, 32'h0, 32'h0, 0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        repeat (40) @(negedge clk);

        @(posedge clk); #1;
        mthi = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mtlo = 1'b0;
        @(negedge clk);
        chk("mtlo_lo", lo, 32'hDEAD_BEEF);
        chk("mtlo_hi", hi, 32'h1234_5678);
        chk("mtlo_done", {31'h0, done}, 32'h0);

        @(posedge clk); #1;
        mthi = 1'b1; wdata = 32'h0000_5555;
        issue(MD_MULTU, 32'd6, 32'd7, 32'h0, 32'd42, 1);
        mthi = 1'b0;
        wait_done();
        start = 1'b1; op = MD_DIVU; a = 32'd42; b = 32'd5;
        exp_q.push_back({32'd2, 32'd8});
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("b2b_busy", {31'h0, busy}, 32'h1);
        wait_done();

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit for the CPU execute stage. Holds the architectural HI/LO registers.
- Upstream of the 32-bit 2:1 writeback select mux. That mux chooses between the ALU result and HI/LO (MFHI/MFLO).
- Accepts one MULT/MULTU/DIV/DIVU per start pulse. Computes with one shift-add or restore step per cycle.
- Asserts busy so the pipeline stalls on HI/LO hazards.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request to begin an operation; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  WIDTH  rs operand (multiplicand / dividend)
- b  in  WIDTH  rt operand (multiplier / divisor)
- mthi  in  1  write wdata to HI
- mtlo  in  1  write wdata to LO
- wdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when the result lands in HI/LO
- hi  out  WIDTH  HI register (remainder / product upper half)
- lo  out  WIDTH  LO register (quotient / product lower half)

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. This applies mid-operation too: the partial result is discarded and HI/LO are cleared.
- FSM states: IDLE -> CALC -> FIX -> IDLE.
- IDLE, start=1 at edge t:
  - latch op.
  - latch |a| and |b| for signed ops (the raw value for unsigned), plus the sign flags.
  - counter=0, state=CALC.
- CALC:
  - multiply: one shift-add step per cycle into a 2*WIDTH accumulator.
  - divide: one restoring step per cycle (shift remainder, trial-subtract divisor, set quotient bit).
  - After WIDTH steps (cycles t+1..t+32 for WIDTH=32), state=FIX.
- FIX (cycle t+33):
  - signed multiply: negate the product if the signs differ.
  - signed divide: quotient negative if the signs differ; remainder takes the sign of the dividend.
  - Write hi/lo at the edge ending FIX, set done=1, state=IDLE.
- Timing: busy=1 for cycles t+1..t+33. done=1 for cycle t+34 only; busy=0 in that cycle. Total latency is WIDTH+2 cycles from start to done.
- A new start is accepted in the cycle done is high (state is IDLE).
- busy and done are registered outputs. hi/lo are driven directly from the registers.
- Divide by zero (b=0), signed or unsigned: lo=all ones, hi=a (original, unsigned bit pattern). This overrides sign fix.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF): lo=0x80000000, hi=0. This falls out of the algorithm and must not trap.
- start while busy: ignored, no queueing.
- mthi/mtlo while busy: ignored. mthi/mtlo in IDLE: the register updates at the next edge; done is not pulsed.
- start together with mthi/mtlo in IDLE: start wins and the move is dropped.
- mthi and mtlo together: both written with wdata.
- HI/LO hold their value otherwise. Operands a/b may change after the start cycle without effect.

Decomposition:
- Shared package cpu_pkg holds:
  - op encodings MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11
  - state enum md_state_t {MD_IDLE, MD_CALC, MD_FIX}
- One sub-module is natural: muldiv_step. It is combinational and performs one iteration (shift-add or trial-subtract) on the accumulator. It is instanced once; the FSM and HI/LO registers stay in muldiv_unit.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at t -> busy t+1..t+33; done only at t+34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB(-21).
- DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1). Then DIVU a=100 b=7 -> lo=14, hi=2.
- Corner cases:
  - DIVU a=0x1234 b=0 -> lo=0xFFFFFFFF, hi=0x1234.
  - DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Busy interference:
  - During busy, start with new operands plus mthi wdata=0xAAAA -> both ignored; the result is that of the first op.
  - Next op: rst at t+10 -> next cycle busy=0, hi=lo=0, no done pulse.
- In IDLE, mtlo wdata=0xDEADBEEF -> lo=0xDEADBEEF next cycle, hi unchanged, done stays 0.
- start+mthi in the same IDLE cycle -> mthi dropped; back-to-back start in the done cycle is accepted.
